// File: rtl/pkt_gate_pkg.sv
// rtl/pkt_gate_pkg.sv - shared types and constants for the packet gate
// Purpose: FSM state encoding and verdict encoding used by pkt_gate.
// Ports: none (package).
package pkt_gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FWD  = 2'b01,
    DROP = 2'b10
  } state_e;

  localparam logic VERDICT_SEND = 1'b1;

endpackage

// File: rtl/pkt_gate_if.sv
// rtl/pkt_gate_if.sv - AXI4-Stream bundle with master/slave views
// Purpose: groups tdata/tkeep/tuser/tvalid/tready/tlast of one stream.
// Ports (modports):
//   master - drives tdata, tkeep, tuser, tvalid, tlast; receives tready
//   slave  - receives tdata, tkeep, tuser, tvalid, tlast; drives tready
interface pkt_gate_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, output tkeep, output tuser, output tvalid,
                  output tlast, input tready);

  modport slave  (input tdata, input tkeep, input tuser, input tvalid,
                  input tlast, output tready);

endinterface

// File: rtl/pkt_gate_fifo.sv
// rtl/pkt_gate_fifo.sv - first-word-fall-through FIFO with full/empty flags
// Purpose: synchronous FIFO; the head entry is visible on rd_data_o as soon
//          as it is written (after the writing clock edge).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   wr_en_i         - write request (accepted when not full, or when a read
//                     happens in the same cycle)
//   wr_data_i       - write data
//   rd_en_i         - pop the head entry (ignored when empty)
//   rd_data_o       - head entry
//   full_o, empty_o - occupancy flags
module gate_fifo #(
  parameter int WIDTH      = 1,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q;
  logic [DEPTH_BITS-1:0] rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;
  logic [DEPTH_BITS:0]   count_d;
  logic                  do_wr;
  logic                  do_rd;

  assign empty_o   = (count_q == '0);
  // count never exceeds DEPTH, so the top bit alone means "full"
  assign full_o    = count_q[DEPTH_BITS];
  assign do_rd     = rd_en_i && !empty_o;
  // a write into a full FIFO is fine when the head leaves in the same cycle
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + (DEPTH_BITS+1)'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - (DEPTH_BITS+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pkt_gate.sv
// rtl/pkt_gate.sv - buffers packets and forwards or drops each on the filter verdict
// Purpose: every incoming packet is held in a word FIFO; each rising edge of
//          send_rd queues one verdict (send). Packets and verdicts pair in
//          FIFO order: verdict 1 streams the packet to m_axis, 0 discards it.
// Optional: PKT_GATE_STATS_EN enables the fwd_count/drop_count counters;
//           without it both outputs are tied to zero.
// Ports:
//   axi_aclk, axi_aresetn - clock, asynchronous active-low reset
//   s_axis                - ingress stream (slave)
//   m_axis                - egress stream (master)
//   send, send_rd         - verdict value and verdict-valid level
//   verdict_overflow      - sticky: verdict lost because verdict FIFO full
//   fwd_count, drop_count - packet statistics
module pkt_gate
  import pkt_gate_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH     = 256,
  parameter int C_S_AXIS_DATA_WIDTH     = 256,
  parameter int C_M_AXIS_TUSER_WIDTH    = 128,
  parameter int C_S_AXIS_TUSER_WIDTH    = 128,
  parameter int DATA_FIFO_DEPTH_BITS    = 6,
  parameter int VERDICT_FIFO_DEPTH_BITS = 2
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  pkt_gate_if.slave   s_axis,
  pkt_gate_if.master  m_axis,
  input  logic        send,
  input  logic        send_rd,
  output logic        verdict_overflow,
  output logic [31:0] fwd_count,
  output logic [31:0] drop_count
);

  localparam int ENTRY_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8
                         + C_S_AXIS_TUSER_WIDTH + 1;

  state_e               state_q;
  logic                 init_q;
  logic                 send_rd_q;
  logic                 ovf_q;

  logic [ENTRY_W-1:0]   data_wr;
  logic [ENTRY_W-1:0]   data_head;
  logic                 data_full;
  logic                 data_empty;
  logic                 data_push;
  logic                 data_pop;
  logic                 head_tlast;
  logic                 last_pop;

  logic                 v_push;
  logic                 v_pop;
  logic                 v_head;
  logic                 v_full;
  logic                 v_empty;

  logic                 s_tready;
  logic                 m_tvalid;

  // ready stays low until the first edge after reset release
  assign s_tready      = init_q && !data_full;
  assign s_axis.tready = s_tready;
  assign data_push     = s_axis.tvalid && s_tready;
  assign data_wr       = {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast};
  assign head_tlast    = data_head[0];

  assign m_tvalid      = (state_q == FWD) && !data_empty;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tdata  = data_head[ENTRY_W-1 -: C_M_AXIS_DATA_WIDTH];
  assign m_axis.tkeep  = data_head[ENTRY_W-1-C_M_AXIS_DATA_WIDTH -: C_M_AXIS_DATA_WIDTH/8];
  assign m_axis.tuser  = data_head[C_M_AXIS_TUSER_WIDTH:1];
  assign m_axis.tlast  = head_tlast;

  // FWD pops on handshake; DROP drains one word per cycle regardless of tready
  assign data_pop = ((state_q == FWD) && m_tvalid && m_axis.tready)
                 || ((state_q == DROP) && !data_empty);
  assign last_pop = data_pop && head_tlast;

  // one verdict per rising edge of the send_rd level
  assign v_push = send_rd && !send_rd_q;
  assign v_pop  = last_pop;

  gate_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
  ) u_data_fifo (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .wr_en_i   (data_push),
    .wr_data_i (data_wr),
    .rd_en_i   (data_pop),
    .rd_data_o (data_head),
    .full_o    (data_full),
    .empty_o   (data_empty)
  );

  gate_fifo #(
    .WIDTH      (1),
    .DEPTH_BITS (VERDICT_FIFO_DEPTH_BITS)
  ) u_verdict_fifo (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .wr_en_i   (v_push),
    .wr_data_i (send),
    .rd_en_i   (v_pop),
    .rd_data_o (v_head),
    .full_o    (v_full),
    .empty_o   (v_empty)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      send_rd_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      init_q    <= 1'b1;
      send_rd_q <= send_rd;
      if (v_push && v_full && !v_pop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!v_empty && !data_empty) begin
            state_q <= (v_head == VERDICT_SEND) ? FWD : DROP;
          end
        end
        FWD, DROP: begin
          if (last_pop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign verdict_overflow = ovf_q;

`ifdef PKT_GATE_STATS_EN
  logic [31:0] fwd_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (last_pop && (state_q == FWD))  fwd_cnt_q  <= fwd_cnt_q + 32'd1;
      if (last_pop && (state_q == DROP)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign fwd_count  = fwd_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign fwd_count  = 32'd0;
  assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_gate.sv
// tb/tb_pkt_gate.sv - self-checking bench for pkt_gate
module tb_pkt_gate;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int EW = DW + DW/8 + UW + 1;

`ifdef PKT_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [EW-1:0] word_t;

  logic        clk;
  logic        rst_n;
  logic        send;
  logic        send_rd;
  logic        verdict_overflow;
  logic [31:0] fwd_count;
  logic [31:0] drop_count;

  pkt_gate_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  pkt_gate_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  pkt_gate dut (
    .axi_aclk         (clk),
    .axi_aresetn      (rst_n),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .send             (send),
    .send_rd          (send_rd),
    .verdict_overflow (verdict_overflow),
    .fwd_count        (fwd_count),
    .drop_count       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    tv_seen = 0;
  word_t got_q[$];
  word_t exp_q[$];
  word_t cur_pkt[$];
  word_t pend_w[$];
  int    pend_len[$];
  bit    vq[$];
  int    exp_fwd = 0;
  int    exp_drop = 0;
  bit    exp_ovf = 1'b0;

  // egress monitor: values at the negedge are those seen by the next posedge
  always @(negedge clk) begin
    if (m_if.tvalid === 1'b1) begin
      tv_seen++;
      if (m_if.tready === 1'b1)
        got_q.push_back({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast});
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic word_t rand_word(input bit last);
    word_t w;
    for (int i = 0; i < EW; i++) w[i] = 1'($urandom_range(0, 1));
    w[0] = last;
    return w;
  endfunction

  function automatic logic [31:0] cnt_exp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic gen_pkt(input int len);
    cur_pkt.delete();
    for (int i = 0; i < len; i++) cur_pkt.push_back(rand_word(i == len - 1));
  endtask

  // reference model: verdicts pair with whole packets strictly in order
  task automatic model_resolve();
    while (vq.size() > 0 && pend_len.size() > 0) begin
      bit v;
      int n;
      v = vq.pop_front();
      n = pend_len.pop_front();
      for (int i = 0; i < n; i++) begin
        word_t w;
        w = pend_w.pop_front();
        if (v) exp_q.push_back(w);
      end
      if (v) exp_fwd++;
      else   exp_drop++;
    end
  endtask

  task automatic model_clear();
    got_q.delete(); exp_q.delete(); pend_w.delete(); pend_len.delete(); vq.delete();
    exp_fwd = 0; exp_drop = 0; exp_ovf = 1'b0;
  endtask

  task automatic push_pkt();
    foreach (cur_pkt[i]) begin
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      s_if.tvalid = 1'b1;
      {s_if.tdata, s_if.tkeep, s_if.tuser, s_if.tlast} = cur_pkt[i];
      while (!acc) begin
        @(negedge clk);
        acc = s_if.tready;
        @(posedge clk); #1;
        n++;
        if (!acc && n > 200) begin
          checks++; errors++;
          $display("FAIL push_timeout word %0d tready stuck low", i);
          s_if.tvalid = 1'b0;
          return;
        end
      end
    end
    s_if.tvalid = 1'b0;
    foreach (cur_pkt[i]) pend_w.push_back(cur_pkt[i]);
    pend_len.push_back(cur_pkt.size());
    model_resolve();
  endtask

  task automatic give_verdict(input bit v, input int hold);
    send = v;
    send_rd = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    send_rd = 1'b0;
    @(posedge clk); #1;
    if (vq.size() == 4) exp_ovf = 1'b1;
    else vq.push_back(v);
    model_resolve();
  endtask

  task automatic wait_drain(input bit toggle, input int extra);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size()) begin
      @(posedge clk); #1;
      if (toggle) m_if.tready = ~m_if.tready;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL drain_timeout got %0d words exp %0d", got_q.size(), exp_q.size());
        break;
      end
    end
    m_if.tready = 1'b1;
    repeat (extra) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; send = 1'b0; send_rd = 1'b0; m_if.tready = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_if.tvalid); end
    checks++; if (verdict_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", verdict_overflow); end
    checks++; if (fwd_count !== 32'd0 || drop_count !== 32'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", fwd_count, drop_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL release_tready_early got %b exp 0", s_if.tready); end
    @(posedge clk); #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b exp 1", s_if.tready); end
  endtask

  task automatic test_fwd_single();
    gen_pkt(4);
    push_pkt();
    repeat (2) begin @(posedge clk); #1; end
    give_verdict(1'b1, 1);
    wait_drain(1'b0, 6);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fwd_single_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fwd_single_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fwd_count !== cnt_exp(exp_fwd)) begin
      errors++; $display("FAIL fwd_single_count got %0d exp %0d", fwd_count, cnt_exp(exp_fwd)); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_drop();
    int tv0;
    tv0 = tv_seen;
    gen_pkt(4);
    push_pkt();
    repeat (2) begin @(posedge clk); #1; end
    give_verdict(1'b0, 1);
    wait_drain(1'b0, 6);
    checks++; if (tv_seen != tv0) begin errors++; $display("FAIL drop_tvalid seen %0d cycles exp 0", tv_seen - tv0); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL drop_words got %0d exp 0", got_q.size()); end
    checks++; if (drop_count !== cnt_exp(exp_drop)) begin
      errors++; $display("FAIL drop_count got %0d exp %0d", drop_count, cnt_exp(exp_drop)); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit verd [3];
    verd[0] = 1'b1; verd[1] = 1'b0; verd[2] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      gen_pkt((p == 0) ? 1 : int'($urandom_range(2, 6)));
      push_pkt();
    end
    for (int p = 0; p < 3; p++) give_verdict(verd[p], 5);
    wait_drain(1'b0, 10);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fwd_count !== cnt_exp(exp_fwd) || drop_count !== cnt_exp(exp_drop)) begin
      errors++; $display("FAIL b2b_counts got %0d/%0d exp %0d/%0d", fwd_count, drop_count,
                         cnt_exp(exp_fwd), cnt_exp(exp_drop)); end
    got_q.delete(); exp_q.delete();
    // no verdict left over: a new packet must wait for its own verdict
    gen_pkt(2);
    push_pkt();
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d words exp 0", got_q.size()); end
    give_verdict(1'b1, 5);
    wait_drain(1'b0, 4);
    checks++; if (got_q.size() != 2 || exp_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL b2b_tail got %0d words exp 2", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    gen_pkt(int'($urandom_range(10, 16)));
    push_pkt();
    give_verdict(1'b1, 1);
    wait_drain(1'b1, 6);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_full();
    int tv0;
    tv0 = tv_seen;
    gen_pkt(64);
    push_pkt();
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b exp 0", s_if.tready); end
    repeat (3) @(negedge clk);
    checks++; if (s_if.tready !== 1'b0 || tv_seen != tv0) begin
      errors++; $display("FAIL full_hold tready %b tvalid cycles %0d exp 0/0", s_if.tready, tv_seen - tv0); end
    @(posedge clk); #1;
    give_verdict(1'b1, 1);
    wait_drain(1'b0, 4);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b exp 1", s_if.tready); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    int tv0;
    tv0 = tv_seen;
    for (int k = 0; k < 4; k++) give_verdict(1'($urandom_range(0, 1)), 1);
    checks++; if (verdict_overflow !== exp_ovf) begin
      errors++; $display("FAIL ovf_at4 got %b exp %b", verdict_overflow, exp_ovf); end
    give_verdict(1'b1, 1);
    checks++; if (verdict_overflow !== exp_ovf) begin
      errors++; $display("FAIL ovf_at5 got %b exp %b", verdict_overflow, exp_ovf); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (tv_seen != tv0) begin errors++; $display("FAIL ovf_tvalid seen %0d cycles exp 0", tv_seen - tv0); end
    rst_n = 1'b0;
    model_clear();
    #2;
    checks++; if (verdict_overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset got %b exp 0", verdict_overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    gen_pkt(10);
    push_pkt();
    give_verdict(1'b1, 1);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (got_q.size() < 3) begin errors++; $display("FAIL mid_start got %0d words exp >=3", got_q.size()); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b exp 0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL mid_tready got %b exp 0", s_if.tready); end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale got %0d words exp 0", got_q.size()); end
    gen_pkt(5);
    push_pkt();
    give_verdict(1'b1, 1);
    wait_drain(1'b0, 4);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mid_after_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mid_after_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fwd_count !== cnt_exp(exp_fwd)) begin
      errors++; $display("FAIL mid_after_count got %0d exp %0d", fwd_count, cnt_exp(exp_fwd)); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_fwd_single();
    test_drop();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_gate.md
Name: pkt_gate

Overview:
- Downstream neighbour of the filter stage in the nf10_filter datapath.
- Buffers each incoming AXI4-Stream packet while the parser/filter decides on it.
- Consumes the filter's per-packet verdict (send / send_rd), then either forwards the whole packet to the master AXIS port or discards it.
- Sits between the input arbiter branch and the output queues.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width (must equal master)
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width
- DATA_FIFO_DEPTH_BITS, 6, log2 of packet word FIFO depth (64 words)
- VERDICT_FIFO_DEPTH_BITS, 2, log2 of verdict FIFO depth (4 entries)

Ports:
- axi_aclk  in  1  single clock
- axi_aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  packet data
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata
- s_axis_tvalid  in  1  slave valid
- s_axis_tready  out  1  slave ready
- s_axis_tlast  in  1  end of packet
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  forwarded data
- m_axis_tkeep  out  C_M_AXIS_DATA_WIDTH/8  forwarded byte enables
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  forwarded metadata
- m_axis_tvalid  out  1  master valid
- m_axis_tready  in  1  master ready
- m_axis_tlast  out  1  end of forwarded packet
- send  in  1  filter verdict: 1 forward, 0 drop
- send_rd  in  1  verdict-valid level; held high until the filter sees hdr_clear
- verdict_overflow  out  1  sticky: a verdict arrived while the verdict FIFO was full
- fwd_count  out  32  forwarded packet count (stats build only)
- drop_count  out  32  dropped packet count (stats build only)

Behaviour:
- Reset (axi_aresetn low, asynchronous):
  - Both FIFOs empty; state IDLE; send_rd_d = 0.
  - s_axis_tready = 0, m_axis_tvalid = 0, verdict_overflow = 0, counters = 0.
  - A partial packet in flight is lost; m_axis_tvalid drops in the same instant.
  - After release, s_axis_tready rises on the first clock edge.
- Ingress:
  - s_axis_tready = !data_full.
  - Word written on tvalid && tready. tdata, tkeep, tuser and tlast are stored together in one entry.
  - First-word-fall-through: a word written at edge N is visible at the FIFO head after edge N.
- Verdict capture:
  - send_rd_d is a registered copy of send_rd.
  - Push occurs when send_rd && !send_rd_d, i.e. exactly one push per rising edge of the level. The pushed value is send.
  - Push while the verdict FIFO is full (and no pop in the same cycle): verdict discarded, verdict_overflow set until reset.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- State machine, evaluated in IDLE:
  - IDLE: if verdict and data FIFOs are both non-empty, go to FWD if the head verdict is 1, else DROP. Otherwise stay.
  - FWD:
    - m_axis_* driven directly from the data FIFO head; m_axis_tvalid = !data_empty.
    - Pop on m_axis_tvalid && m_axis_tready.
    - On a popped word with tlast: pop the verdict, go to IDLE, increment fwd_count.
  - DROP:
    - m_axis_tvalid = 0.
    - Pop one data word per cycle while non-empty.
    - On tlast: pop the verdict, go to IDLE, increment drop_count.
- Latency and order:
  - First output word is valid one cycle after the state leaves IDLE.
  - Minimum latency: 2 cycles after both the head word and the verdict are present.
  - One idle cycle between packets.
  - Packets leave in arrival order; verdicts pair with packets in FIFO order.
- Data FIFO full: ingress stalls. Egress continues only if a verdict is present.
- Single-word packet (tlast on first word): handled identically, one pop.
- m_axis_tready low in FWD: data holds stable; no pop.

Optional Feature:
- PKT_GATE_STATS_EN defined:
  - fwd_count and drop_count are 32-bit counters that wrap at 2^32.
  - Each updates on its own tlast pop.
- PKT_GATE_STATS_EN undefined: both outputs tied to 0; no counter flops.

Decomposition:
- Shared package pkt_gate_pkg:
  - state encodings IDLE = 2'b00, FWD = 2'b01, DROP = 2'b10
  - verdict encoding VERDICT_SEND = 1'b1
- One sub-module, gate_fifo: parameterised width and depth, first-word-fall-through, full/empty flags.
  - Instantiated twice: data FIFO with width tdata + tkeep + tuser + 1; verdict FIFO with width 1.

Test Plan:
- Single 4-word packet; one send_rd pulse with send = 1 arriving 3 cycles after tlast -> 4 words out unchanged, tlast on word 4, fwd_count = 1.
- Same packet with send = 0 -> m_axis_tvalid never asserted, data FIFO empty within 4 cycles, drop_count = 1.
- Three back-to-back packets with verdicts 1, 0, 1; send_rd held high 5 cycles each -> packets 1 and 3 forwarded, packet 2 dropped, exactly three verdicts consumed.
- m_axis_tready toggled 0/1 every cycle during FWD -> no word lost or duplicated; 64-word packet with no verdict -> s_axis_tready = 0 after 64 writes.
- Five verdict rising edges with no packet data -> 4 stored, verdict_overflow = 1.
- Assert axi_aresetn low mid-FWD of a 10-word packet -> m_axis_tvalid = 0 immediately; after release, FIFOs empty and the next packet is forwarded normally.
